mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 141 ++++++++++++++
 tb/tb_mult_div_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - multi-cycle MULT/DIV unit with architectural HI/LO registers
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             is_unsigned,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE,
        S_DIVZ
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   mag_b;
    logic               is_div;
    logic               sign_p;
    logic               sign_r;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic               load;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_mult)     state_nxt = S_MULT;
                else if (start_div) state_nxt = (op_b == '0) ? S_DIVZ : S_DIV;
            end
            S_MULT, S_DIV: begin
                if (abort)          state_nxt = S_IDLE;
                else if (cnt == '0) state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = abort ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_DIVZ:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
    assign done     = (state == S_DONE) || (state == S_DIVZ);
    assign div_zero = (state == S_DIVZ);

    always_comb begin
        a_neg    = !is_unsigned && op_a[WIDTH-1];
        b_neg    = !is_unsigned && op_b[WIDTH-1];
        mag_a_in = a_neg ? -op_a : op_a;
        mag_b_in = b_neg ? -op_b : op_b;
        load     = (state == S_IDLE) && (state_nxt == S_MULT || state_nxt == S_DIV);

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b0, mag_b};

        // Signed results are produced from magnitudes, so a single negate suffices.
        prod_fix = sign_p ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix  = sign_p ? -acc_lo : acc_lo;
        rem_fix  = sign_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mag_b  <= '0;
            is_div <= 1'b0;
            sign_p <= 1'b0;
            sign_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (load) begin
                cnt    <= CW'(WIDTH - 1);
                acc_hi <= '0;
                acc_lo <= mag_a_in;
                mag_b  <= mag_b_in;
                is_div <= (state_nxt == S_DIV);
                sign_p <= a_neg ^ b_neg;
                sign_r <= a_neg;
            end else if ((state == S_MULT || state == S_DIV) && !abort) begin
                cnt <= cnt - 1'b1;
                if (state == S_MULT) begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end else if (!div_diff[WIDTH+1]) begin
                    acc_hi <= div_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else if (state == S_FIX && !abort) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb/tb_mult_div_ctrl.sv - directed and randomized check of mult_div_ctrl against an arithmetic model
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_mult;
    logic        start_div;
    logic        is_unsigned;
    logic        abort;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .is_unsigned (is_unsigned),
        .abort       (abort),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one instruction, from plain 64-bit arithmetic.
    task automatic model(input bit m, input bit u, input logic [31:0] a, input logic [31:0] b,
                         output bit dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        dz = 1'b0;
        if (m) begin
            if (u) p = {32'b0, a} * {32'b0, b};
            else   p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else if (u) begin
            exp_lo = a / b;
            exp_hi = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = sa / sb;
            r = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
    endtask

    task automatic do_op(input string tag, input bit m, input bit both, input bit u,
                         input logic [31:0] a, input logic [31:0] b, input bit noise);
        bit dz;
        bit seen;
        int busy_cnt;
        int n;
        logic [31:0] old_hi, old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(m || both, u, a, b, dz);
        start_mult  = m || both;
        start_div   = !m || both;
        is_unsigned = u;
        op_a        = a;
        op_b        = b;
        step();
        start_mult = 1'b0;
        start_div  = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (n = 0; n < 60; n++) begin
            if (busy && done) chk({tag, "_busy_and_done"}, {busy, done}, 2'b00);
            if (busy) begin
                busy_cnt++;
                if ({hi, lo} !== {old_hi, old_lo}) chk({tag, "_hilo_stable"}, {hi, lo}, {old_hi, old_lo});
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (noise) begin
                start_mult = 1'($urandom_range(0, 1));
                start_div  = 1'($urandom_range(0, 1));
                op_a       = $urandom;
                op_b       = $urandom;
            end
            step();
        end
        start_mult = 1'b0;
        start_div  = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(n), dz ? 64'd0 : 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'd33);
        chk({tag, "_div_zero"}, 64'(div_zero), 64'(dz));
        chk({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        step();
        chk({tag, "_done_one_cycle"}, {61'd0, done, div_zero, busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_mult = 1'b0;
        start_div = 1'b0;
        is_unsigned = 1'b0;
        abort = 1'b0;
        op_a = '0;
        op_b = '0;
        #12;
        chk("reset_state", {hi, lo}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        rst_n = 1'b1;
        #1;

        do_op("mult_neg2x3", 1, 0, 0, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_neg2x3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op("multu_max", 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("div_m7_2", 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_7_2", 0, 0, 1, 32'd7, 32'd2, 0);
        chk("divu_7_2_const", {hi, lo}, {32'd1, 32'd3});
        do_op("preload", 0, 0, 1, 32'h5678_1234, 32'h0001_0000, 0);
        chk("preload_const", {hi, lo}, {32'h1234, 32'h5678});
        do_op("divz", 0, 0, 0, 32'd99, 32'd0, 0);
        chk("divz_const", {hi, lo}, {32'h1234, 32'h5678});
        do_op("div_ovf", 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_const", {hi, lo}, {32'h0, 32'h8000_0000});
        do_op("both_start", 0, 1, 0, 32'd1000, 32'hFFFF_FFF6, 0);
        chk("both_start_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_D8F0);

        // abort asserted in IDLE together with start must not block the start
        start_mult = 1'b1; abort = 1'b1; op_a = 32'd5; op_b = 32'd7; is_unsigned = 1'b0;
        step();
        start_mult = 1'b0; abort = 1'b0;
        chk("abort_idle_accepts", 64'(busy), 64'd1);
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_to_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 36; i++) begin
            if (done) chk("abort_no_done", 64'(done), 64'd0);
            step();
        end
        chk("abort_hilo", {hi, lo}, {exp_hi, exp_lo});

        start_div = 1'b1; op_a = 32'd1234; op_b = 32'd10;
        step();
        start_div = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("reset_mid_hilo", {hi, lo}, 64'd0);
        chk("reset_mid_flags", {61'd0, busy, done, div_zero}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (done || busy) chk("reset_no_done", {busy, done}, 2'b00);
            step();
        end
        do_op("after_reset", 1, 0, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 0,
                  1'($urandom_range(0, 1)), ra, rb, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
